// File: rtl/simd_alu_pkg.sv
// Shared definitions for the pipelined SIMD vector ALU.
//   - opcode encodings (legacy ALU set plus lane-wise REM)
//   - FSM state encoding for the top-level sequencer
//   - is_div_op(): true for the iterative (multi-cycle) opcodes
package simd_alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b0111;
  localparam logic [3:0] OP_DIV = 4'b1100;
  localparam logic [3:0] OP_REM = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/simd_div_lane.sv
// One lane of the restoring unsigned divider, one quotient bit per cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           load dividend/divisor and perform the first step
//   step            perform one further step (driven by the top-level counter)
//   dividend        LANE_W-bit dividend, sampled on start
//   divisor         LANE_W-bit divisor, sampled on start
//   quotient        quotient after LANE_W total steps
//   remainder       remainder after LANE_W total steps
//   dbz             captured divisor is zero
// A zero divisor needs no special case: every trial subtraction succeeds,
// so the quotient fills with ones and the dividend shifts into the remainder.
module simd_div_lane #(
  parameter int unsigned LANE_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic [LANE_W-1:0] dividend,
  input  logic [LANE_W-1:0] divisor,
  output logic [LANE_W-1:0] quotient,
  output logic [LANE_W-1:0] remainder,
  output logic              dbz
);

  logic [LANE_W-1:0] rem_q, rem_d;
  logic [LANE_W-1:0] quo_q, quo_d;
  logic [LANE_W-1:0] div_q, div_d;

  logic [LANE_W-1:0] src_rem;
  logic [LANE_W-1:0] src_quo;
  logic [LANE_W-1:0] src_div;
  logic [LANE_W:0]   partial;
  logic              fits;

  // start folds the operand load into the first shift/subtract step
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    src_rem = start ? '0 : rem_q;
    src_quo = start ? dividend : quo_q;
    src_div = start ? divisor : div_q;
    partial = {src_rem, src_quo[LANE_W-1]};
    fits    = (partial >= {1'b0, src_div});
    if (start || step) begin
      rem_d = fits ? LANE_W'(partial - {1'b0, src_div}) : partial[LANE_W-1:0];
      quo_d = {src_quo[LANE_W-2:0], fits};
      div_d = src_div;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      div_q <= div_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign dbz       = (div_q == '0);

endmodule

// File: rtl/simd_vec_alu_pipe.sv
// Parametrised SIMD vector ALU with valid/ready handshakes on both sides.
// Single-cycle ops register their result directly; DIV/REM run LANES
// lockstep restoring dividers for LANE_W cycles.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (operands, op captured on accept)
//   operand1, operand2    LANES x LANE_W vectors, lane i at [i*LANE_W +: LANE_W]
//   op                    4-bit opcode
//   out_valid / out_ready result handshake
//   result                lane-wise result
//   lane_zero             per-lane result==0
//   zero_flag             lane_zero[0] (legacy compatibility)
//   div_by_zero           per-lane divisor==0 for DIV/REM, else 0
module simd_vec_alu_pipe
  import simd_alu_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] operand1,
  input  logic [LANES*LANE_W-1:0] operand2,
  input  logic [3:0]              op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] result,
  output logic [LANES-1:0]        lane_zero,
  output logic                    zero_flag,
  output logic [LANES-1:0]        div_by_zero
);

  localparam int unsigned VEC_W = LANES * LANE_W;
  localparam int unsigned CNT_W = $clog2(LANE_W + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_rem_q, is_rem_d;
  logic [VEC_W-1:0]   result_q, result_d;
  logic [LANES-1:0]   lane_zero_q, lane_zero_d;
  logic [LANES-1:0]   dbz_q, dbz_d;

  logic               accept;
  logic               div_start;
  logic               div_step;
  logic               div_last;
  logic [VEC_W-1:0]   alu_res;
  logic [VEC_W-1:0]   quo_vec;
  logic [VEC_W-1:0]   rem_vec;
  logic [LANES-1:0]   dbz_vec;
  logic [LANE_W-1:0]  lane_a, lane_b, lane_r;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign div_start = accept && is_div_op(op);
  // start performs step 1, so the counter begins at 1 and stops at LANE_W
  assign div_last  = (cnt_q == CNT_W'(LANE_W));
  assign div_step  = (state_q == DIV) && !div_last;

  // Single-cycle lane-wise datapath
  always_comb begin
    alu_res = '0;
    lane_a  = '0;
    lane_b  = '0;
    lane_r  = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      lane_a = operand1[i*LANE_W +: LANE_W];
      lane_b = operand2[i*LANE_W +: LANE_W];
      case (op)
        OP_AND:  lane_r = lane_a & lane_b;
        OP_OR:   lane_r = lane_a | lane_b;
        OP_XOR:  lane_r = lane_a ^ lane_b;
        OP_ADD:  lane_r = lane_a + lane_b;
        OP_SUB:  lane_r = lane_a - lane_b;
        OP_MUL:  lane_r = lane_a * lane_b;
        default: lane_r = '0;
      endcase
      alu_res[i*LANE_W +: LANE_W] = lane_r;
    end
  end

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    simd_div_lane #(.LANE_W(LANE_W)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .step      (div_step),
      .dividend  (operand1[g*LANE_W +: LANE_W]),
      .divisor   (operand2[g*LANE_W +: LANE_W]),
      .quotient  (quo_vec[g*LANE_W +: LANE_W]),
      .remainder (rem_vec[g*LANE_W +: LANE_W]),
      .dbz       (dbz_vec[g])
    );
  end

  // Sequencer: next state and result capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_rem_d    = is_rem_q;
    result_d    = result_q;
    dbz_d       = dbz_q;
    lane_zero_d = lane_zero_q;
    case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && out_ready) state_d = IDLE;
        if (accept) begin
          if (is_div_op(op)) begin
            state_d  = DIV;
            cnt_d    = CNT_W'(1);
            is_rem_d = (op == OP_REM);
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            dbz_d    = '0;
          end
        end
      end
      DIV: begin
        if (div_last) begin
          state_d  = DONE;
          result_d = is_rem_q ? rem_vec : quo_vec;
          dbz_d    = dbz_vec;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    for (int i = 0; i < int'(LANES); i++) begin
      lane_zero_d[i] = (result_d[i*LANE_W +: LANE_W] == '0);
    end
    // flags stay cleared until the first result is written
    if (result_d == result_q) lane_zero_d = lane_zero_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_rem_q    <= 1'b0;
      result_q    <= '0;
      lane_zero_q <= '0;
      dbz_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_rem_q    <= is_rem_d;
      result_q    <= result_d;
      lane_zero_q <= (state_d == DONE && state_q != DONE) || (accept && !is_div_op(op))
                     ? lane_zero_calc(result_d) : lane_zero_d;
      dbz_q       <= dbz_d;
    end
  end

  function automatic logic [LANES-1:0] lane_zero_calc(input logic [VEC_W-1:0] v);
    logic [LANES-1:0] z;
    z = '0;
    for (int i = 0; i < int'(LANES); i++) z[i] = (v[i*LANE_W +: LANE_W] == '0);
    return z;
  endfunction

  assign out_valid   = (state_q == DONE);
  assign result      = result_q;
  assign lane_zero   = lane_zero_q;
  assign zero_flag   = lane_zero_q[0];
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_simd_vec_alu_pipe.sv
// Self-checking bench for simd_vec_alu_pipe: directed literal cases followed
// by randomized traffic, all checked by a cycle-level behavioural model.
module tb_simd_vec_alu_pipe;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 32;
  localparam int unsigned VEC_W  = LANES * LANE_W;

  typedef logic [VEC_W-1:0]  vec_t;
  typedef logic [LANE_W-1:0] lane_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  vec_t             operand1, operand2;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  vec_t             result;
  logic [LANES-1:0] lane_zero;
  logic             zero_flag;
  logic [LANES-1:0] div_by_zero;

  int tests = 0;
  int fails = 0;

  simd_vec_alu_pipe #(.LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .operand1    (operand1),
    .operand2    (operand2),
    .op          (op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .lane_zero   (lane_zero),
    .zero_flag   (zero_flag),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input vec_t act, input vec_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t pack4(input lane_t l0, input lane_t l1, input lane_t l2, input lane_t l3);
    return {l3, l2, l1, l0};
  endfunction

  // Reference semantics, lane by lane, straight from the opcode table
  function automatic void model_op(input logic [3:0] o, input vec_t a, input vec_t b,
                                   output vec_t r, output logic [LANES-1:0] dz);
    lane_t x, y, z;
    r  = '0;
    dz = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      x = a[i*LANE_W +: LANE_W];
      y = b[i*LANE_W +: LANE_W];
      case (o)
        4'b0000: z = x & y;
        4'b0001: z = x | y;
        4'b0010: z = x ^ y;
        4'b0101: z = x + y;
        4'b0110: z = x - y;
        4'b0111: z = x * y;
        4'b1100: begin dz[i] = (y == 0); z = (y == 0) ? '1 : x / y; end
        4'b1101: begin dz[i] = (y == 0); z = (y == 0) ? x : x % y; end
        default: z = '0;
      endcase
      r[i*LANE_W +: LANE_W] = z;
    end
  endfunction

  function automatic logic [LANES-1:0] zeros_of(input vec_t v);
    logic [LANES-1:0] z;
    for (int i = 0; i < int'(LANES); i++) z[i] = (v[i*LANE_W +: LANE_W] == 0);
    return z;
  endfunction

  // Behavioural model state: a pending divide is just a countdown
  bit               m_armed = 0;
  bit               m_valid, m_clean;
  int               m_busy;
  vec_t             m_result, m_pend;
  logic [LANES-1:0] m_dbz, m_pend_dbz;

  always @(negedge clk) begin
    bit   m_in_ready;
    vec_t r;
    logic [LANES-1:0] dz;
    m_in_ready = (m_busy == 0) && (!m_valid || out_ready);
    if (m_armed) begin
      check("in_ready", in_ready, m_in_ready);
      check("out_valid", out_valid, m_valid);
      if (m_valid || m_clean) begin
        check("result", result, m_clean ? '0 : m_result);
        check("lane_zero", lane_zero, m_clean ? '0 : zeros_of(m_result));
        check("zero_flag", zero_flag, m_clean ? 1'b0 : (m_result[LANE_W-1:0] == 0));
        check("div_by_zero", div_by_zero, m_clean ? '0 : m_dbz);
      end
    end
    if (rst) begin
      m_armed = 1;
      m_valid = 0;
      m_clean = 1;
      m_busy  = 0;
    end else if (m_armed) begin
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_valid  = 1;
          m_result = m_pend;
          m_dbz    = m_pend_dbz;
        end
      end else begin
        if (m_valid && out_ready) m_valid = 0;
        if (in_valid && m_in_ready) begin
          m_clean = 0;
          model_op(op, operand1, operand2, r, dz);
          if (op == 4'b1100 || op == 4'b1101) begin
            m_busy     = LANE_W;
            m_valid    = 0;
            m_pend     = r;
            m_pend_dbz = dz;
          end else begin
            m_valid  = 1;
            m_result = r;
            m_dbz    = '0;
          end
        end
      end
    end
  end

  // Present an op from posedge+1 until accepted; returns at accept edge + 1
  task automatic issue(input logic [3:0] o, input vec_t a, input vec_t b);
    bit got;
    int n;
    got = 0;
    n = 0;
    in_valid = 1; op = o; operand1 = a; operand2 = b;
    while (!got && n < 200) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 0;
    if (!got) check("accept_timeout", 0, 1);
  endtask

  // Cycles from presentation until out_valid is seen; leaves us at that negedge
  task automatic wait_valid(input string name, input int exp_lat);
    int k;
    k = 1;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      k++;
      if (k > 100) break;
    end
    check(name, k, exp_lat);
  endtask

  function automatic lane_t rnd_lane();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return 1;
      2: return lane_t'($urandom_range(0, 15));
      3: return '1;
      default: return lane_t'($urandom);
    endcase
  endfunction

  logic [3:0] op_pool [11] = '{4'b0000, 4'b0001, 4'b0010, 4'b0101, 4'b0110, 4'b0111,
                               4'b1100, 4'b1101, 4'b1010, 4'b0011, 4'b1111};

  initial begin
    vec_t xor_exp;
    rst = 1; in_valid = 0; out_ready = 1; op = '0; operand1 = '0; operand2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", result, 0);
    check("rst_flags", {zero_flag, lane_zero, div_by_zero}, 0);
    @(posedge clk); #1;

    issue(4'b0101, pack4(1, 2, 32'hFFFFFFFF, 5), pack4(1, 3, 1, 32'hFFFFFFFB));
    wait_valid("add_latency", 1);
    check("add_result", result, pack4(2, 5, 0, 0));
    check("add_lane_zero", lane_zero, 4'b1100);
    check("add_zero_flag", zero_flag, 0);
    @(posedge clk); #1;

    issue(4'b0111, pack4(32'h10000, 7, 3, 0), pack4(32'h10000, 6, 4, 9));
    wait_valid("mul_latency", 1);
    check("mul_result", result, pack4(0, 42, 12, 0));
    check("mul_lane_zero", lane_zero, 4'b1001);
    check("mul_zero_flag", zero_flag, 1);
    @(posedge clk); #1;

    issue(4'b0110, pack4(0, 10, 5, 0), pack4(1, 3, 5, 0));
    wait_valid("sub_latency", 1);
    check("sub_result", result, pack4(32'hFFFFFFFF, 7, 0, 0));
    @(posedge clk); #1;

    issue(4'b1100, pack4(100, 7, 0, 9), pack4(7, 7, 5, 0));
    wait_valid("div_latency", 33);
    check("div_result", result, pack4(14, 1, 0, 32'hFFFFFFFF));
    check("div_dbz", div_by_zero, 4'b1000);
    check("div_lane_zero", lane_zero, 4'b0100);
    @(posedge clk); #1;

    issue(4'b1101, pack4(100, 7, 0, 9), pack4(7, 7, 5, 0));
    wait_valid("rem_latency", 33);
    check("rem_result", result, pack4(2, 0, 0, 9));
    check("rem_dbz", div_by_zero, 4'b1000);
    @(posedge clk); #1;

    // backpressure then drain + accept in the same cycle
    out_ready = 0;
    xor_exp = pack4(32'hFFFFFFFF, 0, 4, 0);
    issue(4'b0010, pack4(32'hF0F0F0F0, 1, 2, 3), pack4(32'h0F0F0F0F, 1, 6, 3));
    wait_valid("xor_latency", 1);
    check("xor_result", result, xor_exp);
    check("xor_lane_zero", lane_zero, 4'b1010);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_result_hold", result, xor_exp);
    end
    @(posedge clk); #1;
    out_ready = 1;
    issue(4'b0000, pack4(32'hFF00FF00, 32'hFFFFFFFF, 0, 32'h12345678),
                   pack4(32'h0F0F0F0F, 0, 32'hFFFFFFFF, 32'hFFFFFFFF));
    wait_valid("and_b2b_latency", 1);
    check("and_result", result, pack4(32'h0F000F00, 0, 0, 32'h12345678));
    check("and_lane_zero", lane_zero, 4'b0110);
    @(posedge clk); #1;

    // reset in the middle of a divide
    issue(4'b1100, pack4(1000, 2000, 3000, 4000), pack4(3, 0, 7, 9));
    repeat (9) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_result", result, 0);
    @(posedge clk); #1;
    issue(4'b0001, pack4(1, 0, 0, 32'h80000000), pack4(2, 0, 4, 0));
    wait_valid("or_latency", 1);
    check("or_result", result, pack4(3, 0, 4, 32'h80000000));
    check("or_lane_zero", lane_zero, 4'b0010);
    @(posedge clk); #1;

    issue(4'b1010, pack4(5, 6, 7, 8), pack4(1, 2, 3, 4));
    wait_valid("illegal_latency", 1);
    check("illegal_result", result, 0);
    check("illegal_lane_zero", lane_zero, 4'b1111);
    check("illegal_zero_flag", zero_flag, 1);
    @(posedge clk); #1;

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 7);
      op        = op_pool[$urandom_range(0, 10)];
      operand1  = pack4(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
      operand2  = pack4(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
      rst       = ($urandom_range(0, 399) == 0);
      @(posedge clk); #1;
    end
    rst = 0; in_valid = 0; out_ready = 1;
    repeat (40) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/simd_vec_alu_pipe.md
Name: simd_vec_alu_pipe

Overview:
- Parametrised, sequential successor to the fixed 4x32 combinational SIMD ALU in the array-processor datapath.
- Operates on LANES independent lanes of LANE_W bits each. Results and per-lane flags are registered.
- Operands enter and results leave through valid/ready handshakes.
- Lane-wise unsigned divide and remainder run iteratively over LANE_W cycles; all other ops complete in 1 cycle.

Parameters:
- LANES, 4: number of SIMD lanes.
- LANE_W, 32: bits per lane. VEC_W = LANES*LANE_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept this cycle.
- operand1  in  VEC_W  lane i = bits [i*LANE_W +: LANE_W].
- operand2  in  VEC_W  same lane mapping.
- op  in  4  opcode.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  consumer accepts result.
- result  out  VEC_W  lane-wise result.
- lane_zero  out  LANES  bit i = (result lane i == 0).
- zero_flag  out  1  equal to lane_zero[0], for compatibility with the existing ALU.
- div_by_zero  out  LANES  bit i set if a DIV/REM op had operand2 lane i == 0.

Behaviour:
- Reset: all outputs 0, state IDLE, in_ready=1 the cycle after rst drops. rst mid-divide aborts; no result is emitted.
- Accept when in_valid && in_ready. Operands and op are captured on accept and do not need to be held afterwards.
- Opcodes (unchanged from the existing ALU, plus REM):
  - 0000 AND, 0001 OR, 0010 XOR: bitwise over the full vector.
  - 0101 ADD, 0110 SUB: per lane, mod 2^LANE_W, no carry between lanes.
  - 0111 MUL: per lane, low LANE_W bits of the product.
  - 1100 DIV: per-lane unsigned quotient (new; the existing ALU divides the whole vector).
  - 1101 REM: per-lane unsigned remainder (new).
  - Any other opcode: result 0, lane_zero all 1.
- Divide by zero, per lane: quotient = all ones, remainder = dividend, matching div_by_zero bit = 1. div_by_zero is 0 for non-DIV/REM ops.
- FSM states: IDLE, DIV, DONE.
  - IDLE, accept non-div op -> DONE next cycle, result registered (latency 1).
  - IDLE, accept DIV/REM -> DIV. Counter runs LANE_W cycles, then DONE. out_valid rises LANE_W+1 cycles after accept.
  - DONE: out_valid=1; result, lane_zero, zero_flag and div_by_zero are held stable until out_ready.
  - DONE with out_ready and no new accept -> IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). A new op can be accepted in the same cycle the result drains (back-to-back issue).
  - Simultaneous drain + accept of a non-div op -> stay in DONE; new result appears next cycle and out_valid stays 1.
  - Simultaneous drain + accept of a DIV/REM op -> DIV; out_valid drops to 0.
- in_ready=0 throughout DIV.
- in_valid without in_ready is ignored; nothing is captured.
- All lanes divide in lockstep, so there is no early termination.
- Flags are computed from the final registered result.

Decomposition:
- Package simd_alu_pkg:
  - opcode localparams OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_REM.
  - state enum IDLE/DIV/DONE.
  - helper function is_div_op(op).
- Sub-module simd_div_lane (parameter LANE_W): restoring unsigned divider, one bit per cycle. Ports: start, dividend, divisor; outputs quotient, remainder, dbz.
  - Instantiate LANES copies with a generate loop.
  - The top-level FSM owns the cycle counter; the lanes carry no control state.

Test Plan (LANES=4, LANE_W=32):
- Reset then ADD with lanes op1={1,2,0xFFFFFFFF,5}, op2={1,3,1,0xFFFFFFFB} (lane0 first) -> one cycle later result={2,5,0,0}, lane_zero=4'b1100, zero_flag=0, no carry into lane 3.
- MUL with lane0 0x10000*0x10000 and lane1 7*6 -> lane0=0, lane1=42; SUB lane0 0-1 -> 0xFFFFFFFF.
- DIV op1 lanes {100,7,0,9}, op2 {7,7,5,0} -> out_valid exactly 33 cycles after accept, result {14,1,0,0xFFFFFFFF}, div_by_zero=4'b1000. REM with the same operands -> {2,0,0,9}.
- Backpressure: out_ready=0 for 5 cycles after XOR -> result stable and in_ready=0. Then out_ready=1 with in_valid AND -> drain and accept in the same cycle, and the AND result appears on the next cycle.
- rst asserted 10 cycles into a DIV -> next cycle out_valid=0, in_ready=1, result=0. A following OR completes normally.
- Illegal opcode 4'b1010 -> result 0, lane_zero=4'b1111, zero_flag=1, latency 1.
